// File: rtl/shared_div_scheduler_pkg.sv
// Shared definitions for the time-multiplexed divider: FSM encoding, default
// datapath width and the core-state code the stall logic compares against.
package shared_div_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ITER = 2'b01,
      ST_DONE = 2'b10
   } div_state_t;

   localparam int DATA_BITS_DEFAULT = 8;

   localparam logic [2:0] CORE_STATE_EXECUTE = 3'b101;

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// Operands are captured on start; valid marks the final iteration cycle.
module serial_divider
   import shared_div_scheduler_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] dividend,
   input  logic [DATA_BITS-1:0] divisor,
   output logic [DATA_BITS-1:0] quotient,
   output logic                 valid
);

   localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   logic [DATA_BITS-1:0] dvd_q;
   logic [DATA_BITS-1:0] dvs_q;
   logic [DATA_BITS-1:0] quo_q;
   logic [DATA_BITS-1:0] quo_d;
   logic [DATA_BITS:0]   rem_q;
   logic [DATA_BITS:0]   rem_d;
   logic [DATA_BITS+1:0] trial;
   logic [CNT_W-1:0]     count_q;
   logic                 active_q;

   // The remainder never reaches the divisor, so its MSB is always zero and the
   // trial value equals {rem[DATA_BITS-1:0], next dividend bit}.
   always_comb begin
      trial = {rem_q, dvd_q[DATA_BITS-1]};
      rem_d = trial[DATA_BITS:0];
      quo_d = {quo_q[DATA_BITS-2:0], 1'b0};
      if (trial >= {2'b00, dvs_q}) begin
         rem_d = (DATA_BITS+1)'(trial - {2'b00, dvs_q});
         quo_d = {quo_q[DATA_BITS-2:0], 1'b1};
      end
   end

   assign quotient = quo_d;
   assign valid    = active_q && (count_q == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         dvd_q    <= '0;
         dvs_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         count_q  <= '0;
         active_q <= 1'b0;
      end else if (start) begin
         dvd_q    <= dividend;
         dvs_q    <= divisor;
         quo_q    <= '0;
         rem_q    <= '0;
         count_q  <= CNT_W'(DATA_BITS-1);
         active_q <= 1'b1;
      end else if (active_q) begin
         dvd_q <= {dvd_q[DATA_BITS-2:0], 1'b0};
         quo_q <= quo_d;
         rem_q <= rem_d;
         if (count_q == '0) begin
            active_q <= 1'b0;
         end else begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_div_scheduler.sv
// Round-robin arbiter that shares one serial divider among all thread lanes
// and keeps a per-lane quotient bank that holds until that lane's next done.
module shared_div_scheduler
   import shared_div_scheduler_pkg::*;
#(
   parameter int THREADS_PER_BLOCK = 4,
   parameter int DATA_BITS         = DATA_BITS_DEFAULT
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [THREADS_PER_BLOCK-1:0]           req,
   input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rs_flat,
   input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rt_flat,
   output logic [THREADS_PER_BLOCK-1:0]           done,
   output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] result_flat,
   output logic                                   busy
);

   localparam int IDX_W = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1;

   div_state_t           state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q;
   logic [IDX_W-1:0]     grant_q;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_valid;
   logic                 div_start;
   logic                 div_valid;
   logic [DATA_BITS-1:0] div_quotient;
   logic [DATA_BITS-1:0] result_q [THREADS_PER_BLOCK];
   int                   best_off;
   int                   off;

   // Pick the requester with the smallest circular distance from rr_ptr.
   always_comb begin
      best_off   = THREADS_PER_BLOCK;
      off        = 0;
      pick_idx   = '0;
      pick_valid = 1'b0;
      for (int j = 0; j < THREADS_PER_BLOCK; j++) begin
         off = (j - int'(rr_ptr_q) + THREADS_PER_BLOCK) % THREADS_PER_BLOCK;
         if (req[j] && (off < best_off)) begin
            best_off   = off;
            pick_idx   = IDX_W'(j);
            pick_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               div_start = 1'b1;
               state_d   = ST_ITER;
            end
         end
         ST_ITER: begin
            if (div_valid) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   serial_divider #(
      .DATA_BITS (DATA_BITS)
   ) u_divider (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (rs_flat[int'(pick_idx)*DATA_BITS +: DATA_BITS]),
      .divisor  (rt_flat[int'(pick_idx)*DATA_BITS +: DATA_BITS]),
      .quotient (div_quotient),
      .valid    (div_valid)
   );

   // The result lands on the edge into DONE so it is already valid under done.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
         grant_q  <= '0;
         for (int k = 0; k < THREADS_PER_BLOCK; k++) begin
            result_q[k] <= '0;
         end
      end else begin
         if (div_start) begin
            grant_q <= pick_idx;
         end
         if ((state_q == ST_ITER) && div_valid) begin
            result_q[grant_q] <= div_quotient;
         end
         if (state_q == ST_DONE) begin
            rr_ptr_q <= (grant_q == IDX_W'(THREADS_PER_BLOCK-1)) ? '0 : grant_q + 1'b1;
         end
      end
   end

   always_comb begin
      done = '0;
      if (state_q == ST_DONE) begin
         done[grant_q] = 1'b1;
      end
   end

   for (genvar g = 0; g < THREADS_PER_BLOCK; g++) begin : g_result
      assign result_flat[g*DATA_BITS +: DATA_BITS] = result_q[g];
   end

   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shared_div_scheduler.sv
// Directed bench for the shared divider scheduler: latency, round-robin order,
// divide by zero, operand capture and mid-operation reset.
module tb_shared_div_scheduler;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] rs_flat;
   logic [31:0] rt_flat;
   logic [3:0]  done;
   logic [31:0] result_flat;
   logic        busy;

   int          checks;
   int          failures;
   int          exp_cycle [4];
   logic [7:0]  exp_res [4];

   shared_div_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .rs_flat     (rs_flat),
      .rt_flat     (rt_flat),
      .done        (done),
      .result_flat (result_flat),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [31:0] rs, input logic [31:0] rt);
      req     = r;
      rs_flat = rs;
      rt_flat = rt;
   endtask

   task automatic checkResults(input string tag);
      for (int lane = 0; lane < 4; lane++) begin
         checkOutput($sformatf("%s result[%0d]", tag, lane), 32'(result_flat[lane*8 +: 8]), 32'(exp_res[lane]));
      end
   endtask

   // Called just after a rising edge; that cycle is cycle 0. The bench acts as
   // the requesters: each lane drops req at the edge where it sees its done.
   task automatic watchService(input string tag, input int ncycles, input int chg_cycle,
                               input int chg_lane, input logic [7:0] chg_val);
      logic [3:0] seen;
      logic       exp_busy;
      for (int cyc = 0; cyc < ncycles; cyc++) begin
         @(negedge clk);
         seen     = done;
         exp_busy = 1'b0;
         for (int lane = 0; lane < 4; lane++) begin
            if (exp_cycle[lane] >= 0 && cyc >= exp_cycle[lane] - 8 && cyc <= exp_cycle[lane]) begin
               exp_busy = 1'b1;
            end
         end
         checkOutput($sformatf("%s busy@%0d", tag, cyc), 32'(busy), 32'(exp_busy));
         for (int lane = 0; lane < 4; lane++) begin
            checkOutput($sformatf("%s done[%0d]@%0d", tag, lane, cyc), 32'(done[lane]),
                        32'(cyc == exp_cycle[lane]));
            if (cyc == exp_cycle[lane]) begin
               checkOutput($sformatf("%s result[%0d]@%0d", tag, lane, cyc),
                           32'(result_flat[lane*8 +: 8]), 32'(exp_res[lane]));
            end
         end
         @(posedge clk);
         #1;
         for (int lane = 0; lane < 4; lane++) begin
            if (seen[lane]) req[lane] = 1'b0;
         end
         if (cyc + 1 == chg_cycle) rs_flat[chg_lane*8 +: 8] = chg_val;
      end
      checkResults(tag);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      applyStimulus(4'b0000, 32'd0, 32'd0);
      for (int lane = 0; lane < 4; lane++) exp_res[lane] = 8'd0;

      // Reset state
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("reset done", 32'(done), 32'h0);
      checkOutput("reset busy", 32'(busy), 32'h0);
      checkOutput("reset results", result_flat, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // All four lanes at once from rr_ptr=0: 100/3, 50/5, 255/1, 9/10
      $display("[TB] all lanes simultaneous");
      applyStimulus(4'b1111, {8'd9, 8'd255, 8'd50, 8'd100}, {8'd10, 8'd1, 8'd5, 8'd3});
      exp_cycle = '{9, 19, 29, 39};
      exp_res   = '{8'd33, 8'd10, 8'd255, 8'd0};
      watchService("all4", 41, -1, 0, 8'd0);

      // Single lane 1: 200/7 = 28, rr_ptr back at 0
      $display("[TB] single lane 1");
      applyStimulus(4'b0010, {8'd0, 8'd0, 8'd200, 8'd0}, {8'd0, 8'd0, 8'd7, 8'd0});
      exp_cycle = '{-1, 9, -1, -1};
      exp_res[1] = 8'd28;
      watchService("lane1", 11, -1, 0, 8'd0);

      // Lane 2 divide by zero: 42/0 -> FF, leaves rr_ptr=3
      $display("[TB] divide by zero");
      applyStimulus(4'b0100, {8'd0, 8'd42, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0});
      exp_cycle = '{-1, -1, 9, -1};
      exp_res[2] = 8'hFF;
      watchService("div0", 11, -1, 0, 8'd0);

      // Lanes 0 and 3 together after lane 2: lane 3 first (200/7 with rs
      // changed to 10 in cycle 2), then lane 0 (81/9)
      $display("[TB] round robin and operand change");
      applyStimulus(4'b1001, {8'd200, 8'd0, 8'd0, 8'd81}, {8'd7, 8'd0, 8'd0, 8'd9});
      exp_cycle = '{19, -1, -1, 9};
      exp_res[3] = 8'd28;
      exp_res[0] = 8'd9;
      watchService("rr", 21, 2, 3, 8'd10);

      // Reset during the 4th ITER cycle of a lane 0 divide
      $display("[TB] reset mid operation");
      applyStimulus(4'b0001, {8'd0, 8'd0, 8'd0, 8'd100}, {8'd0, 8'd0, 8'd0, 8'd3});
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         checkOutput($sformatf("pre-reset done@%0d", cyc), 32'(done), 32'h0);
         checkOutput($sformatf("pre-reset busy@%0d", cyc), 32'(busy), 32'(cyc >= 1));
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      req   = 4'b0000;
      @(negedge clk);
      checkOutput("reset-cycle busy", 32'(busy), 32'h1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post-reset busy", 32'(busy), 32'h0);
      checkOutput("post-reset done", 32'(done), 32'h0);
      for (int lane = 0; lane < 4; lane++) exp_res[lane] = 8'd0;
      checkResults("post-reset");
      @(posedge clk);
      #1;
      exp_cycle = '{-1, -1, -1, -1};
      watchService("idle", 12, -1, 0, 8'd0);

      // rr_ptr must be 0 again: lane 0 before lane 1
      $display("[TB] service after reset");
      applyStimulus(4'b0011, {8'd0, 8'd0, 8'd50, 8'd100}, {8'd0, 8'd0, 8'd5, 8'd3});
      exp_cycle = '{9, 19, -1, -1};
      exp_res   = '{8'd33, 8'd10, 8'd0, 8'd0};
      watchService("after-reset", 21, -1, 0, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
